fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the single write port of the team's synchronous FIFO among N_REQ producers.
- Each producer holds a request with its data until it receives a done or err pulse.
- The arbiter issues one FIFO write at a time, waits for the FIFO's wr_ack or overflow response, then rotates priority.
- Sits between the producer blocks and the FIFO write-side signals (data_in, wr_en, full, wr_ack, overflow).

Parameters:
- FIFO_WIDTH, 16, data word width (matches FIFO).
- N_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYC, 15, max WAIT cycles for a FIFO response before error (≥2).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N_REQ  per-requester write request, level, held until done/err.
- req_data  input  N_REQ*FIFO_WIDTH  packed data; slice i = bits [i*FIFO_WIDTH +: FIFO_WIDTH].
- done  output  N_REQ  one-cycle pulse: requester's word accepted (wr_ack seen).
- err  output  N_REQ  one-cycle pulse: write failed (overflow or timeout).
- fifo_data_in  output  FIFO_WIDTH  to FIFO data_in, registered.
- fifo_wr_en  output  1  to FIFO wr_en, registered, one-cycle pulse per write.
- fifo_full  input  1  from FIFO full.
- fifo_wr_ack  input  1  from FIFO wr_ack.
- fifo_overflow  input  1  from FIFO overflow.
- busy  output  1  high while state is WAIT.
- grant_id  output  $clog2(N_REQ)  index of last granted requester.
- drop_cnt  output  8  saturating count of err pulses.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; fifo_wr_en, done, err, busy = 0.
  - fifo_data_in = 0; drop_cnt = 0.
  - grant_id = N_REQ-1, so requester 0 has first priority.
- State IDLE, at a rising edge with |req && !fifo_full:
  - Winner = first i with req[i]=1, searching cyclically from grant_id+1.
  - Register fifo_data_in = slice(winner); fifo_wr_en = 1; grant_id = winner.
  - Clear timeout counter; state → WAIT.
- IDLE with fifo_full=1 or no req: no write; outputs hold except pulses, which return to 0.
- State WAIT:
  - fifo_wr_en forced 0 on the first edge after entry (exactly one-cycle pulse); busy=1.
  - Counter increments each WAIT edge.
  - Responses are sampled from the second WAIT edge onward (the FIFO registers wr_ack/overflow one cycle after sampling wr_en).
- WAIT response handling, evaluated at each edge:
  - fifo_wr_ack=1 → done[grant_id] = 1 for one cycle; state → IDLE.
  - Else fifo_overflow=1 → err[grant_id] = 1; drop_cnt += 1 (saturate at 255); state → IDLE.
  - Else counter == TIMEOUT_CYC → err[grant_id] = 1; drop_cnt += 1; state → IDLE.
  - wr_ack and overflow both high → wr_ack wins.
- Minimum spacing between writes is 3 cycles (issue, FIFO response, arbiter return to IDLE).
- Priority rotates after both done and err. A failed requester is not retried immediately; it re-arbitrates after the others.
- Requester drops req during WAIT: the transaction completes normally and done/err still pulse. Data was captured at grant, so req_data may change after grant.
- done/err are one-hot or zero; never both in the same cycle.
- Reset asserted mid-WAIT: immediate return to reset values, no done/err pulse. Requester must re-request.

Test Plan:
- Single word: req=4'b0001, req_data slice0=16'hA5A5 → fifo_wr_en one-cycle pulse with fifo_data_in=16'hA5A5; FIFO wr_ack next cycle → done=4'b0001 one cycle later; busy high 2 cycles.
- Fairness: req=4'b1111 held, FIFO always acks → grant order 0,1,2,3,0,1; writes every 3 cycles; each done pulse matches grant_id.
- Full stall: fifo_full=1 with req=4'b0010 → no fifo_wr_en for 10 cycles; deassert full → write issued on the next edge.
- Overflow: FIFO answers with overflow=1, wr_ack=0 → err[grant_id]=1, drop_cnt=1, next grant goes to the following requester.
- Timeout: FIFO never responds → err pulses exactly TIMEOUT_CYC=15 WAIT edges after issue; state returns to IDLE.
- Reset mid-WAIT: rst_n=0 one cycle after fifo_wr_en → all outputs 0, grant_id=N_REQ-1, no done/err; after release, req=4'b1111 grants requester 0 first.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one synchronous-FIFO write port among N_REQ producers.
// Issues one write at a time, waits for wr_ack/overflow or a timeout, then rotates priority.
module fifo_wr_arbiter #(
   parameter int unsigned FIFO_WIDTH  = 16,
   parameter int unsigned N_REQ       = 4,
   parameter int unsigned TIMEOUT_CYC = 15
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [N_REQ-1:0]              req,
   input  logic [N_REQ*FIFO_WIDTH-1:0]   req_data,
   output logic [N_REQ-1:0]              done,
   output logic [N_REQ-1:0]              err,
   output logic [FIFO_WIDTH-1:0]         fifo_data_in,
   output logic                          fifo_wr_en,
   input  logic                          fifo_full,
   input  logic                          fifo_wr_ack,
   input  logic                          fifo_overflow,
   output logic                          busy,
   output logic [$clog2(N_REQ)-1:0]      grant_id,
   output logic [7:0]                    drop_cnt
);

   localparam int unsigned GW = $clog2(N_REQ);
   localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
   localparam int unsigned DW = 8;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } state_e;

   state_e                state_q, state_d;
   logic [FIFO_WIDTH-1:0] data_q, data_d;
   logic                  wr_en_q, wr_en_d;
   logic [N_REQ-1:0]      done_q, done_d;
   logic [N_REQ-1:0]      err_q, err_d;
   logic                  busy_q, busy_d;
   logic [GW-1:0]         grant_q, grant_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [DW-1:0]         drop_q, drop_d;

   logic                  found;
   logic [GW-1:0]         winner;
   int unsigned           idx;
   logic                  sampling;
   logic                  timed_out;
   logic                  resp;

   // Cyclic search for the next requester, starting just after the last grant
   always_comb begin
      found  = 1'b0;
      winner = '0;
      idx    = 0;
      for (int unsigned k = 1; k <= N_REQ; k++) begin
         idx = (32'(grant_q) + k) % N_REQ;
         if (!found && req[GW'(idx)]) begin
            found  = 1'b1;
            winner = GW'(idx);
         end
      end
   end

   // Responses are ignored on the first WAIT edge; the FIFO answers one cycle after wr_en
   always_comb begin
      sampling  = (cnt_q != '0);
      timed_out = (cnt_q == CW'(TIMEOUT_CYC - 1));
      resp      = sampling && (fifo_wr_ack || fifo_overflow || timed_out);
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (found && !fifo_full) state_d = S_WAIT;
         S_WAIT:  if (resp) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Output / datapath next values
   always_comb begin
      data_d  = data_q;
      wr_en_d = 1'b0;
      done_d  = '0;
      err_d   = '0;
      busy_d  = 1'b0;
      grant_d = grant_q;
      cnt_d   = cnt_q;
      drop_d  = drop_q;
      case (state_q)
         S_IDLE: begin
            if (found && !fifo_full) begin
               data_d  = req_data[32'(winner)*FIFO_WIDTH +: FIFO_WIDTH];
               wr_en_d = 1'b1;
               grant_d = winner;
               cnt_d   = '0;
               busy_d  = 1'b1;
            end
         end
         S_WAIT: begin
            cnt_d  = cnt_q + CW'(1);
            busy_d = !resp;
            if (sampling) begin
               if (fifo_wr_ack) begin
                  done_d[grant_q] = 1'b1;
               end else if (fifo_overflow || timed_out) begin
                  err_d[grant_q] = 1'b1;
                  if (drop_q != {DW{1'b1}}) drop_d = drop_q + DW'(1);
               end
            end
         end
         default: ;
      endcase
   end

   // Registered outputs and counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q  <= '0;
         wr_en_q <= 1'b0;
         done_q  <= '0;
         err_q   <= '0;
         busy_q  <= 1'b0;
         grant_q <= GW'(N_REQ - 1);
         cnt_q   <= '0;
         drop_q  <= '0;
      end else begin
         data_q  <= data_d;
         wr_en_q <= wr_en_d;
         done_q  <= done_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
         grant_q <= grant_d;
         cnt_q   <= cnt_d;
         drop_q  <= drop_d;
      end
   end

   assign fifo_data_in = data_q;
   assign fifo_wr_en   = wr_en_q;
   assign done         = done_q;
   assign err          = err_q;
   assign busy         = busy_q;
   assign grant_id     = grant_q;
   assign drop_cnt     = drop_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: directed scenarios push expected writes and
// completions; a negedge monitor pops and compares whenever the DUT pulses an output.
module tb_fifo_wr_arbiter;

   localparam int TO = 15;
   localparam int K_WR = 0, K_DONE = 1, K_ERR = 2;
   localparam int M_NONE = 0, M_ACK = 1, M_OVF = 2;

   typedef struct {
      int          kind;
      int          id;
      logic [15:0] data;
      int          drop;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req;
   logic [63:0] req_data;
   logic [3:0]  done;
   logic [3:0]  err;
   logic [15:0] fifo_data_in;
   logic        fifo_wr_en;
   logic        fifo_full;
   logic        fifo_wr_ack;
   logic        fifo_overflow;
   logic        busy;
   logic [1:0]  grant_id;
   logic [7:0]  drop_cnt;

   int   checks = 0;
   int   errors = 0;
   int   mode;
   exp_t q[$];
   int   mn, mx, lat, bn, stall_bad, k;

   fifo_wr_arbiter #(.FIFO_WIDTH(16), .N_REQ(4), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
      .done(done), .err(err), .fifo_data_in(fifo_data_in), .fifo_wr_en(fifo_wr_en),
      .fifo_full(fifo_full), .fifo_wr_ack(fifo_wr_ack), .fifo_overflow(fifo_overflow),
      .busy(busy), .grant_id(grant_id), .drop_cnt(drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // FIFO write-side model: answers one cycle after sampling wr_en
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fifo_wr_ack   <= 1'b0;
         fifo_overflow <= 1'b0;
      end else begin
         fifo_wr_ack   <= fifo_wr_en && (mode == M_ACK);
         fifo_overflow <= fifo_wr_en && (mode == M_OVF);
      end
   end

   function automatic logic [15:0] data_of(input int i);
      case (i)
         0: data_of = 16'hA5A5;
         1: data_of = 16'hB1B1;
         2: data_of = 16'hC2C2;
         default: data_of = 16'hD3D3;
      endcase
   endfunction

   task automatic chk(input bit ok, input string name, input int act, input int exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic exp_wr(input int id);
      exp_t e;
      e.kind = K_WR; e.id = id; e.data = data_of(id); e.drop = 0;
      q.push_back(e);
   endtask

   task automatic exp_rsp(input int kind, input int id, input int drop);
      exp_t e;
      e.kind = kind; e.id = id; e.data = '0; e.drop = drop;
      q.push_back(e);
   endtask

   // Monitor: compare each DUT write or completion pulse against the scoreboard
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (fifo_wr_en) begin
            if (q.size() == 0) begin
               chk(1'b0, "unexpected_wr", int'(grant_id), -1);
            end else begin
               e = q.pop_front();
               chk(e.kind == K_WR, "wr_kind", K_WR, e.kind);
               chk(int'(grant_id) == e.id, "wr_grant", int'(grant_id), e.id);
               chk(fifo_data_in == e.data, "wr_data", int'(fifo_data_in), int'(e.data));
            end
         end
         if (done != 4'b0 || err != 4'b0) begin
            chk($countones(done | err) == 1, "rsp_onehot", int'({done, err}), 0);
            if (q.size() == 0) begin
               chk(1'b0, "unexpected_rsp", int'({done, err}), 0);
            end else begin
               e = q.pop_front();
               chk(e.kind == ((done != 4'b0) ? K_DONE : K_ERR), "rsp_kind",
                   (done != 4'b0) ? K_DONE : K_ERR, e.kind);
               chk(int'(done | err) == (1 << e.id), "rsp_mask", int'(done | err), 1 << e.id);
               chk(int'(drop_cnt) == e.drop, "rsp_drop", int'(drop_cnt), e.drop);
            end
         end
      end
   end

   task automatic check_reset(input string tag);
      chk(fifo_wr_en == 1'b0, {tag, "_wr_en"}, int'(fifo_wr_en), 0);
      chk(done == 4'b0, {tag, "_done"}, int'(done), 0);
      chk(err == 4'b0, {tag, "_err"}, int'(err), 0);
      chk(busy == 1'b0, {tag, "_busy"}, int'(busy), 0);
      chk(fifo_data_in == 16'h0, {tag, "_data"}, int'(fifo_data_in), 0);
      chk(drop_cnt == 8'h0, {tag, "_drop"}, int'(drop_cnt), 0);
      chk(grant_id == 2'd3, {tag, "_grant"}, int'(grant_id), 3);
   endtask

   // Run until n completions; tracks write spacing, completion latency and busy cycles
   task automatic run(input int n, input bit hold, input bit clr_end,
                      output int min_gap, output int max_gap, output int rlat, output int bcnt);
      int resp = 0, cyc = 0, last_wr = -1;
      min_gap = 1000; max_gap = 0; rlat = -1; bcnt = 0;
      while (resp < n && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (busy) bcnt++;
         if (fifo_wr_en) begin
            if (last_wr >= 0) begin
               if (cyc - last_wr < min_gap) min_gap = cyc - last_wr;
               if (cyc - last_wr > max_gap) max_gap = cyc - last_wr;
            end
            last_wr = cyc;
         end
         if (done != 4'b0 || err != 4'b0) begin
            resp++;
            if (last_wr >= 0) rlat = cyc - last_wr;
            if (!hold) req = req & ~(done | err);
         end
      end
      chk(resp == n, "run_responses", resp, n);
      if (clr_end) req = 4'b0;
   endtask

   initial begin
      rst_n    = 1'b0;
      req      = 4'b0;
      fifo_full = 1'b0;
      mode     = M_ACK;
      req_data = {16'hD3D3, 16'hC2C2, 16'hB1B1, 16'hA5A5};
      repeat (2) @(negedge clk);
      check_reset("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // Single word from requester 0
      exp_wr(0); exp_rsp(K_DONE, 0, 0);
      req = 4'b0001;
      run(1, 1'b0, 1'b1, mn, mx, lat, bn);
      chk(lat == 2, "single_latency", lat, 2);
      chk(bn == 2, "single_busy_cycles", bn, 2);

      // FIFO full stalls a pending request
      fifo_full = 1'b1;
      req = 4'b0010;
      exp_wr(1); exp_rsp(K_DONE, 1, 0);
      stall_bad = 0;
      repeat (10) begin
         @(negedge clk);
         if (fifo_wr_en || busy) stall_bad++;
      end
      chk(stall_bad == 0, "stall_no_write", stall_bad, 0);
      fifo_full = 1'b0;
      @(negedge clk);
      chk(fifo_wr_en == 1'b1, "stall_release_wr", int'(fifo_wr_en), 1);
      run(1, 1'b0, 1'b1, mn, mx, lat, bn);

      // Overflow on requester 2, then rotation moves on to requester 3
      mode = M_OVF;
      req  = 4'b1111;
      exp_wr(2); exp_rsp(K_ERR, 2, 1);
      run(1, 1'b1, 1'b0, mn, mx, lat, bn);
      mode = M_ACK;
      exp_wr(3); exp_rsp(K_DONE, 3, 1);
      run(1, 1'b1, 1'b1, mn, mx, lat, bn);
      chk(drop_cnt == 8'd1, "ovf_drop_cnt", int'(drop_cnt), 1);

      // Timeout: FIFO never answers
      mode = M_NONE;
      req  = 4'b0001;
      exp_wr(0); exp_rsp(K_ERR, 0, 2);
      run(1, 1'b0, 1'b1, mn, mx, lat, bn);
      chk(lat == TO, "timeout_latency", lat, TO);
      chk(bn == TO, "timeout_busy_cycles", bn, TO);
      chk(busy == 1'b0, "timeout_idle", int'(busy), 0);

      // Reset asserted in the middle of WAIT
      req = 4'b0100;
      exp_wr(2);
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!fifo_wr_en && k < 20);
      chk(fifo_wr_en == 1'b1, "midwait_issue", int'(fifo_wr_en), 1);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check_reset("midwait");
      rst_n = 1'b1;
      mode  = M_ACK;
      req   = 4'b1111;

      // Fairness with all requesters held
      exp_wr(0); exp_rsp(K_DONE, 0, 0);
      exp_wr(1); exp_rsp(K_DONE, 1, 0);
      exp_wr(2); exp_rsp(K_DONE, 2, 0);
      exp_wr(3); exp_rsp(K_DONE, 3, 0);
      exp_wr(0); exp_rsp(K_DONE, 0, 0);
      exp_wr(1); exp_rsp(K_DONE, 1, 0);
      run(6, 1'b1, 1'b1, mn, mx, lat, bn);
      chk(mn == 3, "fair_min_spacing", mn, 3);
      chk(mx == 3, "fair_max_spacing", mx, 3);

      repeat (4) @(negedge clk);
      chk(q.size() == 0, "scoreboard_drained", q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
